// File: rtl/cnn_window_feeder_if.sv
// cnn_window_feeder_if
// Bundles every non-clock/reset signal of cnn_window_feeder.
//   master : the feeder itself (takes pixel loads, GO and the classifier
//            response; drives BUSY, the window stream and the result)
//   slave  : the surrounding system (image source, simpleCNN, result sink)
// Signals:
//   PIX_WE/PIX_ADDR/PIX_DATA  pixel load port, address = row*IMG_W+col
//   GO, BUSY                  start request / activity flag
//   CNN_START/X/Y/IMGIN       window stream towards the classifier
//   CNN_DONE/CNN_OUT          classifier completion and class
//   RES_VALID/RES_CLASS       captured result
//   TIMEOUT                   abort pulse when the classifier never answers
interface cnn_window_feeder_if #(
  parameter int K     = 5,
  parameter int PIX_W = 8,
  parameter int AW    = 10,
  parameter int CW    = 5
);
  logic                   PIX_WE;
  logic [AW-1:0]          PIX_ADDR;
  logic [PIX_W-1:0]       PIX_DATA;
  logic                   GO;
  logic                   BUSY;
  logic                   CNN_START;
  logic [CW-1:0]          CNN_X;
  logic [CW-1:0]          CNN_Y;
  logic [K*K*PIX_W-1:0]   CNN_IMGIN;
  logic                   CNN_DONE;
  logic [3:0]             CNN_OUT;
  logic                   RES_VALID;
  logic [3:0]             RES_CLASS;
  logic                   TIMEOUT;

  modport master (
    input  PIX_WE, PIX_ADDR, PIX_DATA, GO, CNN_DONE, CNN_OUT,
    output BUSY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN,
           RES_VALID, RES_CLASS, TIMEOUT
  );

  modport slave (
    output PIX_WE, PIX_ADDR, PIX_DATA, GO, CNN_DONE, CNN_OUT,
    input  BUSY, CNN_START, CNN_X, CNN_Y, CNN_IMGIN,
           RES_VALID, RES_CLASS, TIMEOUT
  );
endinterface

// File: rtl/cnn_window_feeder.sv
// cnn_window_feeder
// Buffers an IMG_W x IMG_W image, then on GO streams every KxK window in
// raster order (one per clock) to the simpleCNN classifier and waits for
// its DONE, returning the class or pulsing TIMEOUT if it never answers.
// Ports:
//   CLK  rising-edge clock
//   RST  synchronous active-high reset (image buffer is not cleared)
//   bus  cnn_window_feeder_if.master, see the interface for signal list
module cnn_window_feeder #(
  parameter int IMG_W       = 28,
  parameter int K           = 5,
  parameter int PIX_W       = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 CLK,
  input  logic                 RST,
  cnn_window_feeder_if.master  bus
);
  localparam int NWIN = IMG_W - K + 1;
  localparam int NPIX = IMG_W * IMG_W;
  localparam int AW   = $clog2(NPIX);
  localparam int CW   = $clog2(NWIN);
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int WW   = K * K * PIX_W;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [PIX_W-1:0] img_mem [NPIX];

  logic [1:0]    state_reg;
  logic [CW-1:0] x_reg, y_reg;
  logic [CW-1:0] x_next, y_next;
  logic          start_reg;
  logic [WW-1:0] imgin_reg;
  logic [WW-1:0] win_next;
  logic          busy_reg;
  logic          res_valid_reg;
  logic [3:0]    res_class_reg;
  logic          timeout_reg;
  logic [TW-1:0] wait_cnt_reg;

  logic          go_accept;
  logic          last_win;
  logic          load_win;
  logic [AW-1:0] base_addr;

  assign go_accept = (state_reg == ST_IDLE) && bus.GO;
  assign last_win  = (x_reg == CW'(NWIN - 1)) && (y_reg == CW'(NWIN - 1));
  // A new window is registered on the GO edge (window 0) and on every
  // streaming edge except the one leaving the final window.
  assign load_win  = go_accept || ((state_reg == ST_STREAM) && !last_win);

  // Origin of the window that will be on the outputs after this edge.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (go_accept) begin
      x_next = '0;
      y_next = '0;
    end else if (x_reg == CW'(NWIN - 1)) begin
      x_next = '0;
      y_next = y_reg + 1'b1;
    end else begin
      x_next = x_reg + 1'b1;
    end
  end

  assign base_addr = AW'(y_next) * AW'(IMG_W) + AW'(x_next);

  // Gather all K*K pixels of the next window straight from the buffer so a
  // full window can be issued every clock.
  generate
    for (genvar gi = 0; gi < K * K; gi++) begin : g_win
      localparam int OFS = (gi / K) * IMG_W + (gi % K);
      logic [AW-1:0] pix_addr;
      assign pix_addr = base_addr + AW'(OFS);
      assign win_next[gi*PIX_W +: PIX_W] = img_mem[pix_addr];
    end
  endgenerate

  // Image buffer: loads only while idle and not in the GO cycle, so a
  // running stream can never see its source change underneath it.
  always_ff @(posedge CLK) begin
    if (bus.PIX_WE && (state_reg == ST_IDLE) && !bus.GO &&
        (bus.PIX_ADDR < AW'(NPIX))) begin
      img_mem[bus.PIX_ADDR] <= bus.PIX_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      start_reg     <= 1'b0;
      imgin_reg     <= '0;
      busy_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      res_class_reg <= '0;
      timeout_reg   <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      res_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
      start_reg     <= go_accept;
      if (load_win) begin
        x_reg     <= x_next;
        y_reg     <= y_next;
        imgin_reg <= win_next;
      end
      case (state_reg)
        ST_IDLE: begin
          if (bus.GO) begin
            state_reg <= ST_STREAM;
            busy_reg  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (last_win) begin
            state_reg    <= ST_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        ST_WAIT: begin
          // DONE is checked first so it wins over a simultaneous expiry.
          if (bus.CNN_DONE) begin
            res_class_reg <= bus.CNN_OUT;
            res_valid_reg <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end else if (wait_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
            timeout_reg <= 1'b1;
            busy_reg    <= 1'b0;
            state_reg   <= ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY      = busy_reg;
  assign bus.CNN_START = start_reg;
  assign bus.CNN_X     = x_reg;
  assign bus.CNN_Y     = y_reg;
  assign bus.CNN_IMGIN = imgin_reg;
  assign bus.RES_VALID = res_valid_reg;
  assign bus.RES_CLASS = res_class_reg;
  assign bus.TIMEOUT   = timeout_reg;

endmodule

// File: tb/tb_cnn_window_feeder.sv
// tb_cnn_window_feeder
// Directed bench for cnn_window_feeder with a ramp image
// pixel(r,c) = (r*28+c) & 0xFF and a 16-cycle classifier timeout.
module tb_cnn_window_feeder;
  localparam int TC = 16;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  cnn_window_feeder_if #(.K(5), .PIX_W(8), .AW(10), .CW(5)) bus ();

  cnn_window_feeder #(
    .IMG_W(28), .K(5), .PIX_W(8), .TIMEOUT_CYC(TC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int n;
    int x;
    int y;
    int b0;
    int b24;
    int st;
  } win_vec_t;

  win_vec_t tbl [6];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endtask

  // Starts in window 0's cycle and ends in window 575's cycle.
  task automatic walk_stream(input bit use_tbl, input bit inject);
    for (int n = 0; n < 576; n++) begin
      if (n % 24 == 0 || n == 575) begin
        chk("stream_x", int'(bus.CNN_X), n % 24);
        chk("stream_y", int'(bus.CNN_Y), n / 24);
        chk("stream_busy", int'(bus.BUSY), 1);
      end
      if (n > 0 && bus.CNN_START) chk("stream_start_repeat", 1, 0);
      if (use_tbl) begin
        for (int k = 0; k < 6; k++) begin
          if (tbl[k].n == n) begin
            chk("vec_x", int'(bus.CNN_X), tbl[k].x);
            chk("vec_y", int'(bus.CNN_Y), tbl[k].y);
            chk("vec_byte0", int'(bus.CNN_IMGIN[0 +: 8]), tbl[k].b0);
            chk("vec_byte24", int'(bus.CNN_IMGIN[192 +: 8]), tbl[k].b24);
            chk("vec_start", int'(bus.CNN_START), tbl[k].st);
          end
        end
      end
      if (inject) begin
        bus.GO       = (n == 10);
        bus.PIX_WE   = (n == 11);
        bus.PIX_ADDR = 10'd0;
        bus.PIX_DATA = 8'hFF;
        bus.CNN_DONE = (n == 12);
        bus.CNN_OUT  = 4'd3;
      end
      if (n < 575) tick();
    end
    bus.GO       = 1'b0;
    bus.PIX_WE   = 1'b0;
    bus.CNN_DONE = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    tbl[0] = '{n: 0,   x: 0,  y: 0,  b0: 0,   b24: 116, st: 1};
    tbl[1] = '{n: 1,   x: 1,  y: 0,  b0: 1,   b24: 117, st: 0};
    tbl[2] = '{n: 23,  x: 23, y: 0,  b0: 23,  b24: 139, st: 0};
    tbl[3] = '{n: 24,  x: 0,  y: 1,  b0: 28,  b24: 144, st: 0};
    tbl[4] = '{n: 100, x: 4,  y: 4,  b0: 116, b24: 232, st: 0};
    tbl[5] = '{n: 575, x: 23, y: 23, b0: 155, b24: 15,  st: 0};

    RST = 1'b1;
    bus.PIX_WE = 1'b0; bus.PIX_ADDR = '0; bus.PIX_DATA = '0;
    bus.GO = 1'b0; bus.CNN_DONE = 1'b0; bus.CNN_OUT = '0;
    tick(); tick();
    RST = 1'b0;

    // Ramp image load.
    for (int a = 0; a < 784; a++) begin
      bus.PIX_WE   = 1'b1;
      bus.PIX_ADDR = 10'(a);
      bus.PIX_DATA = 8'(a);
      tick();
    end
    bus.PIX_WE = 1'b0;

    // Reset with random inputs; addresses kept out of range so the image survives.
    RST = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.PIX_WE   = 1'($urandom_range(0, 1));
      bus.PIX_ADDR = 10'($urandom_range(784, 1023));
      bus.PIX_DATA = 8'($urandom_range(0, 255));
      bus.GO       = 1'($urandom_range(0, 1));
      bus.CNN_DONE = 1'($urandom_range(0, 1));
      bus.CNN_OUT  = 4'($urandom_range(0, 15));
      tick();
    end
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_start", int'(bus.CNN_START), 0);
    chk("rst_x", int'(bus.CNN_X), 0);
    chk("rst_y", int'(bus.CNN_Y), 0);
    chk("rst_imgin_nonzero", int'(|bus.CNN_IMGIN), 0);
    chk("rst_res_valid", int'(bus.RES_VALID), 0);
    chk("rst_res_class", int'(bus.RES_CLASS), 0);
    chk("rst_timeout", int'(bus.TIMEOUT), 0);
    RST = 1'b0;
    bus.PIX_WE = 1'b0; bus.GO = 1'b0; bus.CNN_DONE = 1'b0; bus.CNN_OUT = '0;
    tick();

    // Run 1: table-checked stream, DONE with class 7 at t+590.
    bus.GO = 1'b1;
    tick();
    bus.GO = 1'b0;
    walk_stream(1'b1, 1'b0);
    tick(); // t+577
    chk("wait_no_start", int'(bus.CNN_START), 0);
    chk("wait_busy", int'(bus.BUSY), 1);
    chk("wait_x_held", int'(bus.CNN_X), 23);
    chk("wait_y_held", int'(bus.CNN_Y), 23);
    for (int c = 578; c <= 590; c++) tick();
    bus.CNN_DONE = 1'b1;
    bus.CNN_OUT  = 4'd7;
    tick(); // t+591
    bus.CNN_DONE = 1'b0;
    bus.CNN_OUT  = 4'd0;
    chk("done_res_valid", int'(bus.RES_VALID), 1);
    chk("done_res_class", int'(bus.RES_CLASS), 7);
    chk("done_busy", int'(bus.BUSY), 0);
    chk("done_timeout", int'(bus.TIMEOUT), 0);
    tick(); // t+592
    chk("done_res_valid_low", int'(bus.RES_VALID), 0);

    // Run 2: ignored GO/PIX_WE/DONE during stream, then timeout.
    bus.GO = 1'b1;
    tick();
    bus.GO = 1'b0;
    chk("run2_start", int'(bus.CNN_START), 1);
    walk_stream(1'b0, 1'b1);
    chk("run2_last_byte0", int'(bus.CNN_IMGIN[0 +: 8]), 155);
    for (int c = 577; c <= 592; c++) begin
      tick();
      if (c == 577 || c == 592) begin
        chk("run2_wait_timeout", int'(bus.TIMEOUT), 0);
        chk("run2_wait_busy", int'(bus.BUSY), 1);
      end
    end
    tick(); // t+593
    chk("to_timeout", int'(bus.TIMEOUT), 1);
    chk("to_busy", int'(bus.BUSY), 0);
    chk("to_res_class_kept", int'(bus.RES_CLASS), 7);
    chk("to_res_valid", int'(bus.RES_VALID), 0);

    // Run 3: GO in the cycle BUSY falls; pixel 0 untouched; DONE at expiry cycle.
    bus.GO = 1'b1;
    tick();
    bus.GO = 1'b0;
    chk("run3_timeout_low", int'(bus.TIMEOUT), 0);
    walk_stream(1'b1, 1'b0);
    for (int c = 577; c <= 592; c++) tick();
    bus.CNN_DONE = 1'b1;
    bus.CNN_OUT  = 4'd9;
    tick(); // t+593
    bus.CNN_DONE = 1'b0;
    chk("tie_res_valid", int'(bus.RES_VALID), 1);
    chk("tie_res_class", int'(bus.RES_CLASS), 9);
    chk("tie_timeout", int'(bus.TIMEOUT), 0);
    chk("tie_busy", int'(bus.BUSY), 0);
    tick();

    // Run 4: reset at window 100, then write-then-GO visibility and restart.
    bus.GO = 1'b1;
    tick();
    bus.GO = 1'b0;
    for (int n = 1; n <= 100; n++) tick();
    chk("mid_x", int'(bus.CNN_X), 4);
    chk("mid_y", int'(bus.CNN_Y), 4);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_busy", int'(bus.BUSY), 0);
    chk("mid_rst_start", int'(bus.CNN_START), 0);
    chk("mid_rst_x", int'(bus.CNN_X), 0);
    bus.PIX_WE   = 1'b1;
    bus.PIX_ADDR = 10'd0;
    bus.PIX_DATA = 8'h5A;
    tick();
    bus.PIX_WE = 1'b0;
    bus.GO     = 1'b1;
    tick();
    bus.GO = 1'b0;
    chk("restart_start", int'(bus.CNN_START), 1);
    chk("restart_x", int'(bus.CNN_X), 0);
    chk("restart_y", int'(bus.CNN_Y), 0);
    chk("restart_busy", int'(bus.BUSY), 1);
    chk("restart_byte0", int'(bus.CNN_IMGIN[0 +: 8]), 8'h5A);
    tick();
    chk("restart2_start", int'(bus.CNN_START), 0);
    chk("restart2_x", int'(bus.CNN_X), 1);
    chk("restart2_byte0", int'(bus.CNN_IMGIN[0 +: 8]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
